// File: rtl/nhan_acc16_if.sv
// nhan_acc16_if: product-in and result-out handshakes for the nhan_acc16 accumulator.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface nhan_acc16_if #(
  parameter int ACC_W = 24
) ();

  logic             p_valid;
  logic             p_ready;
  logic [15:0]      p_data;
  logic             acc_valid;
  logic             acc_ready;
  logic [ACC_W-1:0] acc_data;

  modport slave (
    input  p_valid,
    input  p_data,
    input  acc_ready,
    output p_ready,
    output acc_valid,
    output acc_data
  );

  modport master (
    output p_valid,
    output p_data,
    output acc_ready,
    input  p_ready,
    input  acc_valid,
    input  acc_data
  );

endinterface

// File: rtl/nhan_acc16.sv
// nhan_acc16: sums a programmed number of 16-bit unsigned products into an
// ACC_W-bit accumulator and holds the total on a valid/ready result handshake.
// Optional feature macro: NHAN_ACC_SAT_EN (saturate on overflow instead of wrapping).
module nhan_acc16 #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  nhan_acc16_if.slave      bus,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic             xfer;
  logic [ACC_W:0]   sum;
  logic             carry;

  // Handshake outputs decode the registered state only.
  always_comb begin
    bus.p_ready   = (state_q == ACC);
    bus.acc_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
  end

  assign bus.acc_data = acc_q;
  assign ovf          = ovf_q;

  // One-bit-wider unsigned sum so the carry out of the accumulator is visible.
  always_comb begin
    xfer  = (state_q == ACC) && bus.p_valid;
    sum   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, bus.p_data};
    carry = sum[ACC_W];
  end

  // Next-state, accumulator, remaining-count and overflow logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (xfer) begin
`ifdef NHAN_ACC_SAT_EN
          // Once clamped the accumulator stays all ones for the rest of the run.
          if (ovf_q || carry) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
`else
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | carry;
`endif
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.acc_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_nhan_acc16.sv
// tb_nhan_acc16: directed tests for nhan_acc16 with a 24-bit and a 16-bit instance.
module tb_nhan_acc16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       busy;
  logic       ovf;
  logic       start16;
  logic [3:0] len16;
  logic       busy16;
  logic       ovf16;

  int total;
  int bad;

  nhan_acc16_if #(.ACC_W(24)) bus24 ();
  nhan_acc16_if #(.ACC_W(16)) bus16 ();

  nhan_acc16 #(.ACC_W(24), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .bus   (bus24.slave),
    .busy  (busy),
    .ovf   (ovf)
  );

  nhan_acc16 #(.ACC_W(16), .CNT_W(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .len   (len16),
    .bus   (bus16.slave),
    .busy  (busy16),
    .ovf   (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; len = '0;
    bus24.p_valid = 1'b0; bus24.p_data = '0; bus24.acc_ready = 1'b0;
    start16 = 1'b0; len16 = '0;
    bus16.p_valid = 1'b0; bus16.p_data = '0; bus16.acc_ready = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus24.p_ready, bus24.acc_valid, busy, ovf} !== 4'b0000 || bus24.acc_data !== 24'h0) begin
      bad++;
      $display("FAIL reset_state: rdy/vld/busy/ovf=%b acc=%h expected 0000 acc=000000",
               {bus24.p_ready, bus24.acc_valid, busy, ovf}, bus24.acc_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    total++;
    if (bus24.p_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_enter_acc: p_ready=%b busy=%b expected 1 1", bus24.p_ready, busy);
    end
    bus24.p_valid = 1'b1; bus24.p_data = 16'hFFFF;
    repeat (3) tick();
    total++;
    if (bus24.acc_valid !== 1'b0 || bus24.acc_data !== 24'h02FFFD) begin
      bad++;
      $display("FAIL basic_third: acc_valid=%b acc=%h expected 0 02fffd", bus24.acc_valid, bus24.acc_data);
    end
    tick();
    bus24.p_valid = 1'b0;
    total++;
    if (bus24.acc_valid !== 1'b1 || bus24.acc_data !== 24'h03FFFC || ovf !== 1'b0 || bus24.p_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: vld=%b acc=%h ovf=%b rdy=%b expected 1 03fffc 0 0",
               bus24.acc_valid, bus24.acc_data, ovf, bus24.p_ready);
    end
    bus24.acc_ready = 1'b1;
    tick();
    bus24.acc_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || bus24.acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_return_idle: busy=%b acc_valid=%b expected 0 0", busy, bus24.acc_valid);
    end
  endtask

  task automatic test_gaps_backpressure();
    logic [15:0] prods [3];
    prods[0] = 16'h0010; prods[1] = 16'h0020; prods[2] = 16'h0030;
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus24.p_valid = 1'b0; bus24.p_data = 16'hDEAD;
      repeat (2) tick();
      if (i == 1) begin
        total++;
        if (bus24.acc_data !== 24'h000010 || bus24.p_ready !== 1'b1) begin
          bad++;
          $display("FAIL gap_hold: acc=%h p_ready=%b expected 000010 1", bus24.acc_data, bus24.p_ready);
        end
      end
      bus24.p_valid = 1'b1; bus24.p_data = prods[i];
      tick();
    end
    // Keep offering a product during DONE: it must not be taken.
    bus24.p_data = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (bus24.acc_data !== 24'h000060 || bus24.acc_valid !== 1'b1 || bus24.p_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold[%0d]: acc=%h vld=%b rdy=%b expected 000060 1 0",
                 c, bus24.acc_data, bus24.acc_valid, bus24.p_ready);
      end
      tick();
    end
    bus24.p_valid = 1'b0;
    bus24.acc_ready = 1'b1;
    tick();
    bus24.acc_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || bus24.acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release: busy=%b acc_valid=%b expected 0 0", busy, bus24.acc_valid);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_acc;
`ifdef NHAN_ACC_SAT_EN
    exp_acc = 16'hFFFF;
`else
    exp_acc = 16'h0001;
`endif
    start16 = 1'b1; len16 = 4'd2;
    tick();
    start16 = 1'b0;
    bus16.p_valid = 1'b1; bus16.p_data = 16'hFFFF;
    tick();
    total++;
    if (ovf16 !== 1'b0 || bus16.acc_data !== 16'hFFFF) begin
      bad++;
      $display("FAIL ovf_first: acc=%h ovf=%b expected ffff 0", bus16.acc_data, ovf16);
    end
    bus16.p_data = 16'h0002;
    tick();
    bus16.p_valid = 1'b0;
    total++;
    if (bus16.acc_valid !== 1'b1 || bus16.acc_data !== exp_acc || ovf16 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_result: vld=%b acc=%h ovf=%b expected 1 %h 1",
               bus16.acc_valid, bus16.acc_data, ovf16, exp_acc);
    end
    bus16.acc_ready = 1'b1;
    tick();
    bus16.acc_ready = 1'b0;
    // A fresh run must clear the sticky flag.
    start16 = 1'b1; len16 = 4'd1;
    tick();
    start16 = 1'b0;
    total++;
    if (ovf16 !== 1'b0 || bus16.acc_data !== 16'h0000) begin
      bad++;
      $display("FAIL ovf_clear_on_start: acc=%h ovf=%b expected 0000 0", bus16.acc_data, ovf16);
    end
    bus16.p_valid = 1'b1; bus16.p_data = 16'h0007;
    tick();
    bus16.p_valid = 1'b0;
    bus16.acc_ready = 1'b1;
    tick();
    bus16.acc_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 4'd0;
    bus24.p_valid = 1'b1; bus24.p_data = 16'h5555;
    tick();
    start = 1'b0;
    total++;
    if (bus24.acc_valid !== 1'b1 || bus24.acc_data !== 24'h0 || bus24.p_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: vld=%b acc=%h rdy=%b expected 1 000000 0",
               bus24.acc_valid, bus24.acc_data, bus24.p_ready);
    end
    tick();
    total++;
    if (bus24.acc_data !== 24'h0) begin
      bad++;
      $display("FAIL zero_len_hold: acc=%h expected 000000", bus24.acc_data);
    end
    bus24.p_valid = 1'b0;
    bus24.acc_ready = 1'b1;
    tick();
    bus24.acc_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0;
    bus24.p_valid = 1'b1; bus24.p_data = 16'h0100;
    repeat (2) tick();
    total++;
    if (bus24.acc_data !== 24'h000200 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_partial: acc=%h busy=%b expected 000200 1", bus24.acc_data, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus24.p_ready, bus24.acc_valid, busy, ovf} !== 4'b0000 || bus24.acc_data !== 24'h0) begin
      bad++;
      $display("FAIL mid_async_reset: rdy/vld/busy/ovf=%b acc=%h expected 0000 000000",
               {bus24.p_ready, bus24.acc_valid, busy, ovf}, bus24.acc_data);
    end
    bus24.p_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    bus24.p_valid = 1'b1; bus24.p_data = 16'h1234;
    tick();
    bus24.p_valid = 1'b0;
    total++;
    if (bus24.acc_valid !== 1'b1 || bus24.acc_data !== 24'h001234) begin
      bad++;
      $display("FAIL mid_fresh_run: vld=%b acc=%h expected 1 001234", bus24.acc_valid, bus24.acc_data);
    end
    bus24.acc_ready = 1'b1;
    tick();
    bus24.acc_ready = 1'b0;
  endtask

  task automatic test_ignored_start();
    start = 1'b1; len = 4'd3;
    tick();
    // Start pulsed in ACC together with the first transfer.
    start = 1'b1; len = 4'd1;
    bus24.p_valid = 1'b1; bus24.p_data = 16'h0001;
    tick();
    start = 1'b0;
    bus24.p_data = 16'h0002;
    tick();
    total++;
    if (bus24.acc_valid !== 1'b0 || bus24.acc_data !== 24'h000003 || bus24.p_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_in_acc: vld=%b acc=%h rdy=%b expected 0 000003 1",
               bus24.acc_valid, bus24.acc_data, bus24.p_ready);
    end
    bus24.p_data = 16'h0003;
    tick();
    bus24.p_valid = 1'b0;
    // Start pulsed in DONE with the result not yet taken.
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0;
    total++;
    if (bus24.acc_valid !== 1'b1 || bus24.acc_data !== 24'h000006 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_in_done: vld=%b acc=%h busy=%b expected 1 000006 1",
               bus24.acc_valid, bus24.acc_data, busy);
    end
    bus24.acc_ready = 1'b1;
    tick();
    bus24.acc_ready = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_not_queued: busy=%b expected 0", busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_not_queued_late: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_gaps_backpressure();
    test_overflow();
    test_zero_len();
    test_reset_mid_run();
    test_ignored_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nhan_acc16.md
# nhan_acc16

Sequential accumulator stage directly downstream of the combinational 8x8 multiplier `nhan16`. It consumes a stream of 16-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator. It then presents the total on a held output handshake. Together with the multiplier it forms a multiply-accumulate (dot-product) datapath.

## Interface
- `ACC_W`, 24: accumulator and result width in bits; legal range 16 to 32.
- `CNT_W`, 4: width of the product-count field; at most 2^CNT_W-1 products per run.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request to begin a run; sampled only in IDLE.
- `len` input CNT_W: number of products to accumulate; sampled together with `start`.
- `p_valid` input 1: product-in valid.
- `p_ready` output 1: product-in ready.
- `p_data` input 16: product from `nhan16.s`, unsigned.
- `acc_valid` output 1: result valid.
- `acc_ready` input 1: result accepted by the consumer.
- `acc_data` output ACC_W: accumulated sum, registered.
- `busy` output 1: high in any state other than IDLE.
- `ovf` output 1: sticky overflow flag for the current run.

## Operation
- States: IDLE, ACC, DONE. The state register is binary-encoded.
- IDLE:
  - `p_ready`=0 and `acc_valid`=0.
  - On `start`=1: clear `acc_data` to 0, clear `ovf`, load `rem`<=`len`.
  - If `len`==0, go to DONE with a result of 0. Otherwise go to ACC.
- ACC:
  - `p_ready`=1.
  - A transfer occurs when `p_valid`&&`p_ready`.
  - On each transfer: `acc_data`<=`acc_data`+{zero-extend `p_data`} and `rem`<=`rem`-1.
  - The transfer with `rem`==1 moves the block to DONE.
  - Cycles with `p_valid`=0 leave all state unchanged.
- DONE:
  - `p_ready`=0 and `acc_valid`=1.
  - `acc_data` and `ovf` are held stable.
  - On `acc_ready`=1, go to IDLE.
- `start` outside IDLE is ignored. It is neither queued nor able to disturb a run.
- Arithmetic: the sum is unsigned and computed ACC_W+1 bits wide. A carry out of bit ACC_W-1 sets `ovf`. Behaviour on overflow is set by the configuration macro.
- `len` and `p_data` are don't-care outside their sampling conditions.

## Timing
- Reset values: state=IDLE, `acc_data`=0, `ovf`=0, `rem`=0, `p_ready`=0, `acc_valid`=0, `busy`=0.
- `p_ready`, `acc_valid` and `busy` are decoded from the registered state only, with no combinational path from inputs.
- `start` in cycle T gives `p_ready`=1 in cycle T+1, or `acc_valid`=1 in T+1 when `len`==0.
- Throughput is one product per cycle when `p_valid` is held high.
- The final transfer at edge E gives `acc_valid`=1 and the final `acc_data` from E onward.
- A result handshake at edge E returns the block to IDLE at E. The earliest next `start` is sampled at edge E+1.
- Minimum run length for `len`=N is N+2 cycles from the `start` cycle to the return to IDLE, assuming `acc_ready` is tied high.
- `rst_n` low at any time, including mid-ACC or in DONE, forces reset values immediately. The partial sum is discarded and no `acc_valid` is emitted.

## Configuration
- `NHAN_ACC_SAT_EN` defined:
  - On carry out, `acc_data` clamps to all ones and stays there for the rest of the run.
  - `ovf`=1.
- `NHAN_ACC_SAT_EN` undefined:
  - `acc_data` wraps modulo 2^ACC_W.
  - `ovf`=1 on the first carry and stays set.

## Test plan
- Basic run: ACC_W=24, `len`=4, four products of 0xFFFF back-to-back -> `acc_data`=0x03FFFC, `ovf`=0, `acc_valid` high on the edge of the 4th transfer.
- Gaps and backpressure: `len`=3, products 0x0010, 0x0020, 0x0030 with 2-cycle `p_valid` gaps; `acc_ready` held low for 5 cycles -> `acc_data`=0x000060 stable throughout, `p_ready`=0 in DONE, return to IDLE on the `acc_ready` edge.
- Overflow (ACC_W=16 instance), products 0xFFFF then 0x0002:
  - Without the macro -> `acc_data`=0x0001, `ovf`=1.
  - With `NHAN_ACC_SAT_EN` -> `acc_data`=0xFFFF, `ovf`=1.
- Zero length: `start` with `len`=0 -> `acc_valid`=1 the next cycle, `acc_data`=0, no product accepted even when `p_valid`=1.
- Reset mid-run: `len`=5, `rst_n` pulsed low after 2 transfers -> all outputs return to reset values immediately; a fresh run of `len`=1 with product 0x1234 then gives `acc_data`=0x001234.
- Ignored start: `start` pulsed while in ACC and while in DONE -> `rem` and `acc_data` are unaffected, and the result matches the original `len`.
